multiplier_8_bits_sequential: RTL and testbench

Sequential 8x8 unsigned shift-and-add multiplier. It sits directly upstream of `full_adder_8_bits_structure` and drives that adder once per cycle, feeding the operand pair A/B and consuming S/COUT. It produces a 16-bit product after a fixed 8-iteration computation and signals completion with a one-cycle DONE pulse. It is the first multi-cycle arithmetic block built on the structural adder.

---
 rtl/multiplier_8_bits_sequential.sv | 111 +++++++++++
 tb/tb_multiplier_8_bits_sequential.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multiplier_8_bits_sequential.sv
// 8x8 unsigned shift-and-add multiplier driving one structural ripple adder.
// One partial-product add per CALC cycle; product lands in P with a DONE pulse.
module full_adder_8_bits_structure (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       CIN,
  output logic [7:0] S,
  output logic       COUT
);
  logic [8:0] c;

  assign c[0] = CIN;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign COUT = c[8];
endmodule

module multiplier_8_bits_sequential (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P,
  output logic        BUSY,
  output logic        DONE
);
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  m, m_nx;
  logic [7:0]  acc, acc_nx;
  logic [7:0]  q, q_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [15:0] p, p_nx;
  logic [7:0]  addend;
  logic [7:0]  sum;
  logic        cout;

  assign addend = q[0] ? m : 8'h00;

  full_adder_8_bits_structure u_add (
    .A    (acc),
    .B    (addend),
    .CIN  (1'b0),
    .S    (sum),
    .COUT (cout)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      state <= state_nx;
      m     <= m_nx;
      acc   <= acc_nx;
      q     <= q_nx;
      cnt   <= cnt_nx;
      p     <= p_nx;
    end
  end

  always_comb begin
    state_nx = state;
    m_nx     = m;
    acc_nx   = acc;
    q_nx     = q;
    cnt_nx   = cnt;
    p_nx     = p;
    unique case (state)
      IDLE: begin
        if (START) begin
          m_nx     = A;
          q_nx     = B;
          acc_nx   = '0;
          cnt_nx   = '0;
          state_nx = CALC;
        end
      end
      CALC: begin
        // carry-out becomes the new MSB so the 9-bit sum is never truncated
        acc_nx = {cout, sum[7:1]};
        q_nx   = {sum[0], q[7:1]};
        cnt_nx = cnt + 3'd1;
        if (cnt == 3'd7) begin
          p_nx     = {cout, sum, q[7:1]};
          state_nx = FINISH;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign P    = p;
  assign BUSY = (state == CALC);
  assign DONE = (state == FINISH);
endmodule

// File: tb/tb_multiplier_8_bits_sequential.sv
// Directed bench for multiplier_8_bits_sequential.
// Each scenario task drives stimulus and checks outputs against hand values.
module tb_multiplier_8_bits_sequential;
  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] P;
  logic        BUSY;
  logic        DONE;

  int passed = 0;
  int total  = 0;
  logic [15:0] last_p = 16'h0000;

  multiplier_8_bits_sequential dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .P     (P),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    START = 1'b0;
    A = 8'h00;
    B = 8'h00;
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    #1;
    total++;
    if ({P, BUSY, DONE} !== {16'h0000, 1'b0, 1'b0})
      $display("FAIL reset_out: P=%h BUSY=%b DONE=%b required P=0000 BUSY=0 DONE=0", P, BUSY, DONE);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({P, BUSY, DONE} !== {16'h0000, 1'b0, 1'b0})
        $display("FAIL reset_idle%0d: P=%h BUSY=%b DONE=%b required 0000 0 0", i, P, BUSY, DONE);
      else passed++;
    end
    last_p = 16'h0000;
  endtask

  // full transaction with cycle-accurate BUSY/DONE/P checks
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string name);
    int busy_cycles;
    busy_cycles = 0;
    @(negedge CLK);
    A = a;
    B = b;
    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (BUSY === 1'b1) busy_cycles++;
      total++;
      if (DONE !== 1'b0 || P !== last_p)
        $display("FAIL %s_calc%0d: DONE=%b P=%h required DONE=0 P=%h", name, i, DONE, P, last_p);
      else passed++;
      step();
    end
    total++;
    if (busy_cycles != 8)
      $display("FAIL %s_busy_len: got %0d required 8", name, busy_cycles);
    else passed++;
    total++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || P !== exp)
      $display("FAIL %s_done: DONE=%b BUSY=%b P=%h required DONE=1 BUSY=0 P=%h", name, DONE, BUSY, P, exp);
    else passed++;
    last_p = exp;
    step();
    total++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || P !== exp)
      $display("FAIL %s_idle: DONE=%b BUSY=%b P=%h required DONE=0 BUSY=0 P=%h", name, DONE, BUSY, P, exp);
    else passed++;
  endtask

  task automatic test_basic();
    run_mul(8'd3, 8'd5, 16'd15, "m3x5");
  endtask

  task automatic test_carry();
    run_mul(8'd255, 8'd255, 16'hFE01, "m255x255");
    run_mul(8'd128, 8'd2, 16'h0100, "m128x2");
  endtask

  task automatic test_zero();
    run_mul(8'd0, 8'd200, 16'h0000, "m0x200");
    run_mul(8'd200, 8'd0, 16'h0000, "m200x0");
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (P !== 16'h0000 || DONE !== 1'b0)
        $display("FAIL zero_hold%0d: P=%h DONE=%b required 0000 0", i, P, DONE);
      else passed++;
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    dones = 0;
    @(negedge CLK);
    A = 8'd10;
    B = 8'd10;
    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      // second request asserted during the 4th CALC cycle, dropped before FINISH
      if (i == 4) begin
        A = 8'd1;
        B = 8'd1;
        START = 1'b1;
      end
      if (i == 6) START = 1'b0;
      step();
      if (DONE === 1'b1) dones++;
      if (i == 8) begin
        total++;
        if (DONE !== 1'b1 || P !== 16'd100)
          $display("FAIL ignore_done: DONE=%b P=%h required DONE=1 P=%h", DONE, P, 16'd100);
        else passed++;
      end
    end
    total++;
    if (dones != 1 || BUSY !== 1'b0)
      $display("FAIL ignore_pulses: dones=%0d BUSY=%b required 1 0", dones, BUSY);
    else passed++;
    total++;
    if (P !== 16'd100)
      $display("FAIL ignore_hold: P=%h required %h", P, 16'd100);
    else passed++;
    last_p = 16'd100;
  endtask

  task automatic test_async_reset();
    int dones;
    dones = 0;
    @(negedge CLK);
    A = 8'd255;
    B = 8'd255;
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (4) step();
    #2 RST_N = 1'b0;
    #1;
    total++;
    if (P !== 16'h0000 || BUSY !== 1'b0 || DONE !== 1'b0)
      $display("FAIL areset_now: P=%h BUSY=%b DONE=%b required 0000 0 0", P, BUSY, DONE);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (DONE === 1'b1) dones++;
    end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (DONE === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || P !== 16'h0000 || BUSY !== 1'b0)
      $display("FAIL areset_quiet: dones=%0d P=%h BUSY=%b required 0 0000 0", dones, P, BUSY);
    else passed++;
    last_p = 16'h0000;
    run_mul(8'd7, 8'd9, 16'd63, "m7x9");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_ignore_start();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
